// File: rtl/riscv_mem_pkg.sv
// Shared types and decode helpers for the data-memory initiator.
package riscv_mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_WAIT = 3'd1,
    RMW_RD  = 3'd2,
    RMW_WR  = 3'd3,
    ACK     = 3'd4
  } state_t;

  function automatic logic is_load(input mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    logic half_s;
    logic word_s;
    half_s = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    word_s = (op == MEM_LW) || (op == MEM_SW);
    return (half_s && off[0]) || (word_s && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extract with sign/zero extension and
// sub-word store merge into the word read back from RAM.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted_s;
  logic [31:0] mask_s;
  logic [31:0] insert_s;

  // Extract/merge for the addressed lane(s); only aligned accesses reach here.
  always_comb begin
    shifted_s = rdata >> {byte_off, 3'b000};
    mask_s    = 32'h0000_0000;
    insert_s  = 32'h0000_0000;
    load_data = 32'h0000_0000;
    case (op)
      MEM_LB:  load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      MEM_LBU: load_data = {24'h00_0000, shifted_s[7:0]};
      MEM_LH:  load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      MEM_LHU: load_data = {16'h0000, shifted_s[15:0]};
      MEM_LW:  load_data = shifted_s;
      MEM_SB: begin
        mask_s   = 32'h0000_00FF << {byte_off, 3'b000};
        insert_s = {24'h00_0000, wdata[7:0]} << {byte_off, 3'b000};
      end
      MEM_SH: begin
        mask_s   = 32'h0000_FFFF << {byte_off[1], 4'b0000};
        insert_s = {16'h0000, wdata} << {byte_off[1], 4'b0000};
      end
      default: load_data = 32'h0000_0000;
    endcase
    store_word = (rdata & ~mask_s) | (insert_s & mask_s);
  end

endmodule

// File: rtl/dmem_master.sv
// Load/store initiator for a single-port word RAM: one request at a time,
// sub-word stores by read-modify-write, PC stalled until the response.
module dmem_master
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              err,
  output logic [ADDR_W-1:0] address_DM,
  output logic              read_enable,
  output logic              write_enable,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  state_t            state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;

  mem_op_t           req_op_s;
  logic              accept_s;
  logic [31:0]       align_load_s;
  logic [31:0]       align_store_s;
  logic              unused_s;

  assign unused_s = ^req_addr[31:ADDR_W];

  mem_lane_align u_align (
    .op         (op_q),
    .byte_off   (addr_q[1:0]),
    .rdata      (data_out),
    .wdata      (wdata_q),
    .load_data  (align_load_s),
    .store_word (align_store_s)
  );

  // Next state, request latch and RAM/core-side outputs.
  always_comb begin
    req_op_s     = mem_op_t'(req_op);
    accept_s     = req_valid && (is_load(req_op_s) || is_store(req_op_s));
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    stall        = 1'b0;
    resp_valid   = 1'b0;
    load_data    = '0;
    err          = 1'b0;
    address_DM   = '0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    data_in      = '0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d    = req_op_s;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata[15:0];
          stall   = 1'b1;
          if (is_misaligned(req_op_s, req_addr[1:0])) begin
            state_d = ACK;
          end else begin
            address_DM = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_op_s == MEM_SW) begin
              write_enable = 1'b1;
              data_in      = req_wdata;
              state_d      = ACK;
            end else if (is_store(req_op_s)) begin
              read_enable = 1'b1;
              state_d     = RMW_RD;
            end else begin
              read_enable = 1'b1;
              state_d     = LD_WAIT;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      LD_WAIT: begin
        resp_valid = 1'b1;
        load_data  = align_load_s;
        state_d    = IDLE;
      end
      RMW_RD: begin
        stall        = 1'b1;
        address_DM   = {addr_q[ADDR_W-1:2], 2'b00};
        write_enable = 1'b1;
        data_in      = align_store_s;
        state_d      = ACK;
      end
      ACK: begin
        resp_valid = 1'b1;
        err        = is_misaligned(op_q, addr_q[1:0]);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence the RAM immediately, including the request-driven accept cycle.
    if (!nRst) begin
      stall        = 1'b0;
      resp_valid   = 1'b0;
      load_data    = '0;
      err          = 1'b0;
      address_DM   = '0;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      data_in      = '0;
    end else begin
      state_d = state_d;
    end
  end

  // State and request-latch registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      op_q    <= MEM_NONE;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench for dmem_master with a registered-read RAM model and a
// response scoreboard.
module tb_dmem_master;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        nRst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        err;
  logic [11:0] address_DM;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] data_in;
  logic [31:0] data_out;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;
  logic        ram_load;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_master #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .load_data    (load_data),
    .err          (err),
    .address_DM   (address_DM),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  // RAM model: registered read, word indexed
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8081_8283;
    end else if (write_enable) begin
      mem[address_DM[11:2]] <= data_in;
    end
    if (read_enable) rd_q <= mem[address_DM[11:2]];
  end
  assign data_out = rd_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: scoreboard pops on every response; quiet outputs otherwise
  always @(negedge clk) begin
    exp_t e;
    if (read_enable || write_enable)
      check("strobe_overlap", {31'b0, read_enable & write_enable}, 32'h0);
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {31'b0, resp_valid}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_data"}, load_data, e.data);
        check({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
        check({e.name, "_resp_stall"}, {31'b0, stall}, 32'h0);
      end
    end else begin
      check("idle_data_err", {load_data[30:0], err}, 32'h0);
    end
  end

  task automatic do_req(input string name, input mem_op_t op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err,
                        input logic exp_re, input logic exp_we, input int exp_lat,
                        input logic [31:0] exp_word);
    exp_t e;
    int   cyc;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    e.name = name; e.data = exp_data; e.err = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    cyc = 1;
    check({name, "_acc_re"}, {31'b0, read_enable}, {31'b0, exp_re});
    check({name, "_acc_we"}, {31'b0, write_enable}, {31'b0, exp_we});
    check({name, "_acc_stall"}, {31'b0, stall}, 32'h1);
    if (exp_re || exp_we)
      check({name, "_acc_addr"}, {20'h0, address_DM}, {20'h0, addr[11:2], 2'b00});
    if (exp_we)
      check({name, "_acc_wdata"}, data_in, exp_word);
    while (!resp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2 && exp_lat == 3) begin
        check({name, "_rmw_we"}, {31'b0, write_enable}, 32'h1);
        check({name, "_rmw_word"}, data_in, exp_word);
        check({name, "_rmw_stall"}, {31'b0, stall}, 32'h1);
      end
    end
    check({name, "_latency"}, cyc, exp_lat);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = MEM_NONE;
  endtask

  initial begin
    nRst = 1'b0; ram_load = 1'b1;
    req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h10; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {stall, resp_valid, read_enable, write_enable, address_DM, 16'h0},
          32'h0);
    check("reset_data_in", data_in, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0; ram_load = 1'b0; nRst = 1'b1;

    // op NONE with valid: ignored
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = MEM_NONE;
    @(negedge clk);
    check("none_stall", {30'b0, stall, read_enable | write_enable}, 32'h0);
    go_idle();

    do_req("lb_011",  MEM_LB,  32'h011, 32'h0, 32'hFFFF_FF82, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    do_req("lbu_013", MEM_LBU, 32'h013, 32'h0, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    do_req("lhu_012", MEM_LHU, 32'h012, 32'h0, 32'h0000_8081, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    do_req("lh_012",  MEM_LH,  32'h012, 32'h0, 32'hFFFF_8081, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    do_req("lb_010",  MEM_LB,  32'h010, 32'h0, 32'hFFFF_FF83, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    do_req("lw_010",  MEM_LW,  32'h010, 32'h0, 32'h8081_8283, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    go_idle();

    do_req("sb_012", MEM_SB, 32'h012, 32'h0000_00AA, 32'h0, 1'b0, 1'b1, 1'b0, 3, 32'h80AA_8283);
    go_idle();
    check("sb_ram_word", mem[4], 32'h80AA_8283);

    // SW then LW back-to-back
    do_req("sw_020", MEM_SW, 32'h020, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1, 2, 32'hDEAD_BEEF);
    do_req("lw_020", MEM_LW, 32'h020, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    do_req("sh_022", MEM_SH, 32'h022, 32'hFFFF_1234, 32'h0, 1'b0, 1'b1, 1'b0, 3, 32'h1234_BEEF);
    go_idle();
    check("sh_ram_word", mem[8], 32'h1234_BEEF);

    do_req("lw_022_mis",  MEM_LW,  32'h022, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2, 32'h0);
    do_req("sh_011_mis",  MEM_SH,  32'h011, 32'h0000_5678, 32'h0, 1'b1, 1'b0, 1'b0, 2, 32'h0);
    do_req("lhu_011_mis", MEM_LHU, 32'h011, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2, 32'h0);
    go_idle();
    check("mis_ram_word", mem[4], 32'h80AA_8283);

    do_req("sb_restore", MEM_SB, 32'h012, 32'h0000_0081, 32'h0, 1'b0, 1'b1, 1'b0, 3, 32'h8081_8283);
    go_idle();

    // SH aborted by reset in RMW_RD: no write may be issued
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = MEM_SH; req_addr = 32'h010; req_wdata = 32'h0000_1234;
    @(negedge clk);
    check("abort_acc_re", {31'b0, read_enable}, 32'h1);
    @(posedge clk); #1;
    nRst = 1'b0;
    @(negedge clk);
    check("abort_rst_out", {29'b0, write_enable, stall, resp_valid}, 32'h0);
    req_valid = 1'b0; req_op = MEM_NONE;
    @(posedge clk); #1;
    nRst = 1'b1;
    @(negedge clk);
    check("abort_idle", {29'b0, write_enable, stall, resp_valid}, 32'h0);
    @(negedge clk);
    check("abort_ram_word", mem[4], 32'h8081_8283);
    do_req("lw_after_abort", MEM_LW, 32'h010, 32'h0, 32'h8081_8283, 1'b0, 1'b1, 1'b0, 2, 32'h0);
    go_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
